// File: rtl/cs_arith_pkg.sv
// cs_arith_pkg: shared defaults and helper types for the carry-select arithmetic blocks.
package cs_arith_pkg;
    localparam int CS_WIDTH = 32;
    localparam int CS_BLOCK = 8;

    function automatic int nb(input int width, input int block);
        return width / block;
    endfunction

    // Per-block candidate record: results for block borrow-in 0 and 1.
    typedef struct packed {
        logic [CS_BLOCK-1:0] diff0;
        logic [CS_BLOCK-1:0] diff1;
        logic                bout0;
        logic                bout1;
    } cand_t;
endpackage

// File: rtl/pipelined_cs_subtractor_if.sv
// pipelined_cs_subtractor_if: operand and result valid/ready channels of the subtractor.
interface pipelined_cs_subtractor_if
    import cs_arith_pkg::*;
#(
    parameter int WIDTH = CS_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout, ovf
    );
    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout, ovf
    );
endinterface

// File: rtl/full_subtractor.sv
// full_subtractor: one-bit a - b - bin cell with borrow-out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/pipelined_cs_subtractor.sv
// pipelined_cs_subtractor: two-stage carry-select a - b - bin with borrow/overflow flags.
module pipelined_cs_subtractor
    import cs_arith_pkg::*;
#(
    parameter int WIDTH = CS_WIDTH,
    parameter int BLOCK = CS_BLOCK
) (
    input logic clk,
    input logic rst_n,
    pipelined_cs_subtractor_if.slave io
);
    localparam int NB = nb(WIDTH, BLOCK);

    if (WIDTH % BLOCK != 0) begin : g_width_check
        $error("WIDTH must be a multiple of BLOCK");
    end

    typedef struct packed {
        logic [BLOCK-1:0] diff0;
        logic [BLOCK-1:0] diff1;
        logic             bout0;
        logic             bout1;
    } blk_t;

    blk_t [NB-1:0]    cand;
    blk_t [NB-1:0]    s1_cand;
    logic             s1_valid;
    logic             s1_bin;
    logic             s1_a_msb;
    logic             s1_b_msb;
    logic [WIDTH-1:0] diff_c;
    logic             br;
    logic             ovf_c;
    logic             s2_load;
    logic             in_fire;

    assign s2_load     = s1_valid && (!io.out_valid || io.out_ready);
    assign io.in_ready = !s1_valid || !io.out_valid || io.out_ready;
    assign in_fire     = io.in_valid && io.in_ready;

    // Each bit owns its borrow wires so the ripple is a chain of distinct nets.
    for (genvar k = 0; k < NB; k++) begin : g_blk
        logic [BLOCK-1:0] d0;
        logic [BLOCK-1:0] d1;
        for (genvar i = 0; i < BLOCK; i++) begin : g_bit
            logic bi0, bi1, bo0, bo1;
            if (i == 0) begin : g_lsb
                assign bi0 = 1'b0;
                assign bi1 = 1'b1;
            end else begin : g_mid
                assign bi0 = g_bit[i-1].bo0;
                assign bi1 = g_bit[i-1].bo1;
            end
            full_subtractor u_fs0 (.a(io.a[k*BLOCK+i]), .b(io.b[k*BLOCK+i]), .bin(bi0), .d(d0[i]), .bout(bo0));
            full_subtractor u_fs1 (.a(io.a[k*BLOCK+i]), .b(io.b[k*BLOCK+i]), .bin(bi1), .d(d1[i]), .bout(bo1));
        end
        assign cand[k] = '{diff0: d0, diff1: d1, bout0: g_bit[BLOCK-1].bo0, bout1: g_bit[BLOCK-1].bo1};
    end

    always_comb begin
        diff_c = '0;
        br = s1_bin;
        for (int j = 0; j < NB; j++) begin
            diff_c[j*BLOCK +: BLOCK] = br ? s1_cand[j].diff1 : s1_cand[j].diff0;
            br = br ? s1_cand[j].bout1 : s1_cand[j].bout0;
        end
        ovf_c = (s1_a_msb != s1_b_msb) && (diff_c[WIDTH-1] != s1_a_msb);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_cand  <= '0;
            s1_bin   <= 1'b0;
            s1_a_msb <= 1'b0;
            s1_b_msb <= 1'b0;
        end else begin
            s1_valid <= in_fire || (s1_valid && !s2_load);
            if (in_fire) begin
                s1_cand  <= cand;
                s1_bin   <= io.bin;
                s1_a_msb <= io.a[WIDTH-1];
                s1_b_msb <= io.b[WIDTH-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            io.out_valid <= 1'b0;
            io.diff      <= '0;
            io.bout      <= 1'b0;
            io.ovf       <= 1'b0;
        end else begin
            io.out_valid <= s2_load || (io.out_valid && !io.out_ready);
            if (s2_load) begin
                io.diff <= diff_c;
                io.bout <= br;
                io.ovf  <= ovf_c;
            end
        end
    end
endmodule

// File: tb/tb_pipelined_cs_subtractor.sv
// tb_pipelined_cs_subtractor: directed and randomized checks of the pipelined subtractor.
module tb_pipelined_cs_subtractor;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    pipelined_cs_subtractor_if #(.WIDTH(32)) io ();
    pipelined_cs_subtractor #(.WIDTH(32), .BLOCK(8)) dut (.clk(clk), .rst_n(rst_n), .io(io));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one operation into an empty pipeline; returns the result and edges to out_valid.
    task automatic run_one(input logic [31:0] ta, input logic [31:0] tb_v, input logic tbin,
                           output logic [31:0] rd, output logic rb, output logic ro, output int lat);
        io.a = ta;
        io.b = tb_v;
        io.bin = tbin;
        io.in_valid = 1'b1;
        io.out_ready = 1'b1;
        tick();
        io.in_valid = 1'b0;
        lat = 1;
        while (!io.out_valid && lat < 10) begin
            tick();
            lat++;
        end
        rd = io.diff;
        rb = io.bout;
        ro = io.ovf;
        tick();
    endtask

    task automatic test_reset();
        io.in_valid = 1'b0;
        io.out_ready = 1'b0;
        io.a = '0;
        io.b = '0;
        io.bin = 1'b0;
        tick();
        tick();
        tests++;
        if ({io.out_valid, io.diff, io.bout, io.ovf} !== 35'd0) begin
            fails++;
            $display("FAIL reset_state: got v=%b d=%h b=%b o=%b expected all 0", io.out_valid, io.diff, io.bout, io.ovf);
        end
        rst_n = 1'b1;
        tick();
        tests++;
        if (io.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_in_ready: got %b expected 1", io.in_ready);
        end
        io.a = 32'd5;
        io.b = 32'd3;
        io.in_valid = 1'b1;
        tick();
        io.a = 32'd0;
        io.b = 32'd1;
        tick();
        io.in_valid = 1'b0;
        tests++;
        if (io.out_valid !== 1'b1 || io.diff !== 32'h2) begin
            fails++;
            $display("FAIL reset_preload: got v=%b d=%h expected v=1 d=00000002", io.out_valid, io.diff);
        end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if ({io.out_valid, io.diff, io.bout, io.ovf} !== 35'd0 || io.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_midstream: got v=%b d=%h b=%b o=%b r=%b expected zeros and ready",
                     io.out_valid, io.diff, io.bout, io.ovf, io.in_ready);
        end
        tick();
        rst_n = 1'b1;
        io.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            tests++;
            if (io.out_valid !== 1'b0) begin
                fails++;
                $display("FAIL reset_no_stale: got out_valid=%b d=%h expected 0", io.out_valid, io.diff);
            end
        end
    endtask

    task automatic test_basic();
        logic [31:0] d;
        logic        bo, ov;
        int          lat;
        run_one(32'd5, 32'd3, 1'b0, d, bo, ov, lat);
        tests++;
        if (d !== 32'h2 || bo !== 1'b0 || ov !== 1'b0) begin
            fails++;
            $display("FAIL basic: got d=%h b=%b o=%b expected d=00000002 b=0 o=0", d, bo, ov);
        end
        tests++;
        if (lat != 2) begin
            fails++;
            $display("FAIL basic_latency: got %0d expected 2", lat);
        end
        tests++;
        if (io.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL basic_drain: got out_valid=%b expected 0", io.out_valid);
        end
    endtask

    task automatic test_borrow();
        logic [31:0] d;
        logic        bo, ov;
        int          lat;
        run_one(32'h0000_0000, 32'h0000_0001, 1'b0, d, bo, ov, lat);
        tests++;
        if (d !== 32'hFFFF_FFFF || bo !== 1'b1 || ov !== 1'b0) begin
            fails++;
            $display("FAIL borrow_all: got d=%h b=%b o=%b expected d=ffffffff b=1 o=0", d, bo, ov);
        end
        run_one(32'h1234_5678, 32'h1234_5678, 1'b1, d, bo, ov, lat);
        tests++;
        if (d !== 32'hFFFF_FFFF || bo !== 1'b1 || ov !== 1'b0) begin
            fails++;
            $display("FAIL borrow_bin: got d=%h b=%b o=%b expected d=ffffffff b=1 o=0", d, bo, ov);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] d;
        logic        bo, ov;
        int          lat;
        run_one(32'h8000_0000, 32'h0000_0001, 1'b0, d, bo, ov, lat);
        tests++;
        if (d !== 32'h7FFF_FFFF || bo !== 1'b0 || ov !== 1'b1) begin
            fails++;
            $display("FAIL ovf_neg: got d=%h b=%b o=%b expected d=7fffffff b=0 o=1", d, bo, ov);
        end
        run_one(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, d, bo, ov, lat);
        tests++;
        if (d !== 32'h8000_0000 || bo !== 1'b1 || ov !== 1'b1) begin
            fails++;
            $display("FAIL ovf_pos: got d=%h b=%b o=%b expected d=80000000 b=1 o=1", d, bo, ov);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_d [5] = '{32'd9, 32'd18, 32'd27, 32'd36, 32'd45};
        logic [31:0] got [$];
        int          cyc [$];
        int          idx = 0;
        io.out_ready = 1'b0;
        io.bin = 1'b0;
        for (int c = 0; c < 6; c++) begin
            io.a = 32'(10 * (idx + 1));
            io.b = 32'(idx + 1);
            io.in_valid = 1'b1;
            #1;
            if (io.in_ready) idx++;
            tick();
        end
        tests++;
        if (idx != 2 || io.in_ready !== 1'b0) begin
            fails++;
            $display("FAIL bp_capacity: got accepts=%0d in_ready=%b expected 2 and 0", idx, io.in_ready);
        end
        tests++;
        if (io.out_valid !== 1'b1 || io.diff !== 32'd9) begin
            fails++;
            $display("FAIL bp_hold: got v=%b d=%h expected v=1 d=00000009", io.out_valid, io.diff);
        end
        io.out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            io.in_valid = idx < 5;
            io.a = 32'(10 * (idx + 1));
            io.b = 32'(idx + 1);
            #1;
            if (io.out_valid) begin
                got.push_back(io.diff);
                cyc.push_back(c);
            end
            if (io.in_valid && io.in_ready) idx++;
            tick();
        end
        io.in_valid = 1'b0;
        tests++;
        if (got.size() != 5) begin
            fails++;
            $display("FAIL bp_count: got %0d results expected 5", got.size());
        end
        for (int i = 0; i < 5 && i < got.size(); i++) begin
            tests++;
            if (got[i] !== exp_d[i] || cyc[i] != cyc[0] + i) begin
                fails++;
                $display("FAIL bp_order[%0d]: got d=%h cycle=%0d expected d=%h cycle=%0d",
                         i, got[i], cyc[i], exp_d[i], cyc[0] + i);
            end
        end
    endtask

    task automatic test_random();
        logic [33:0] exp_q [$];
        logic [33:0] e;
        logic [32:0] r;
        logic [31:0] ra, rb_v;
        logic        rbin;
        logic        stalled = 1'b0;
        logic [33:0] held = '0;
        int          sent = 0;
        int          cycles = 0;
        while ((sent < 10000 || exp_q.size() != 0) && cycles < 60000) begin
            ra = $urandom;
            rb_v = $urandom;
            rbin = 1'($urandom_range(0, 1));
            io.a = ra;
            io.b = rb_v;
            io.bin = rbin;
            io.in_valid = sent < 10000 && $urandom_range(0, 3) != 0;
            io.out_ready = $urandom_range(0, 3) != 0;
            #1;
            if (stalled) begin
                tests++;
                if (io.out_valid !== 1'b1 || {io.ovf, io.bout, io.diff} !== held) begin
                    fails++;
                    $display("FAIL rand_stall: got v=%b %h expected v=1 %h", io.out_valid,
                             {io.ovf, io.bout, io.diff}, held);
                end
            end
            stalled = io.out_valid && !io.out_ready;
            held = {io.ovf, io.bout, io.diff};
            if (io.out_valid && io.out_ready) begin
                e = exp_q.size() != 0 ? exp_q.pop_front() : 34'h3_FFFF_FFFF;
                tests++;
                if ({io.ovf, io.bout, io.diff} !== e) begin
                    fails++;
                    $display("FAIL rand_result: got %h expected %h", {io.ovf, io.bout, io.diff}, e);
                end
            end
            if (io.in_valid && io.in_ready) begin
                r = {1'b0, ra} - {1'b0, rb_v} - 33'(rbin);
                exp_q.push_back({(ra[31] != rb_v[31]) && (r[31] != ra[31]), r});
                sent++;
            end
            tick();
            cycles++;
        end
        io.in_valid = 1'b0;
        tests++;
        if (sent != 10000 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL rand_complete: got sent=%0d pending=%0d expected 10000 and 0", sent, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_borrow();
        test_overflow();
        test_backpressure();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
